mem_req_ctrl: RTL

Upstream command sequencer for the 16x32 single-port `mem` block. It accepts a valid/ready request stream of reads and writes and buffers it in a request FIFO. It issues at most one command per cycle on the memory's En/Rw_en/Rr_en/Address/Data_in pins. Read data is captured on the fixed-latency return and delivered in order on a valid/ready response stream, with credit-based flow control because the memory cannot be back-pressured.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/mem_req_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and latency constants for the mem_req_ctrl slice.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W  = 4;
  localparam int unsigned MEM_DATA_W  = 32;

  // Memory registers Data_out one cycle after a read command.
  localparam int unsigned MEM_RD_LAT  = 1;
  // Request handshake to rsp_valid, empty pipe.
  localparam int unsigned CTRL_RD_LAT = 4;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] rdata;
  } mem_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage; never reset, only written slots are ever presented
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Command sequencer for the single-port mem block: buffers requests,
// issues one command per cycle, captures read data at fixed latency and
// returns it in order under credit-based flow control.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned DATA_W    = MEM_DATA_W,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              mem_en,
  output logic              mem_rw_en,
  output logic              mem_rr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              rd_err
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  localparam int unsigned REQ_CW = $clog2(REQ_DEPTH) + 1;
  localparam int unsigned RSP_CW = $clog2(RSP_DEPTH) + 1;
  // Reads between FIFO pop and response push: issue + capture stages.
  localparam int unsigned INFLIGHT_MAX = CTRL_RD_LAT - MEM_RD_LAT - 1;
  localparam int unsigned INFL_W = $clog2(INFLIGHT_MAX + 1);

  req_t              req_in;
  req_t              req_head;
  logic              req_full;
  logic              req_empty;
  logic [REQ_CW-1:0] req_cnt_unused;
  logic              req_push;

  rsp_t              rsp_in;
  rsp_t              rsp_head;
  logic              rsp_full_unused;
  logic              rsp_empty;
  logic [RSP_CW-1:0] rsp_count;

  logic              issue;
  logic              rd_credit;
  logic [INFL_W-1:0] rd_inflight;

  logic              cap_vld;
  logic [ADDR_W-1:0] cap_addr;

  assign req_ready = !rst && !req_full;
  assign req_push  = req_valid && req_ready;
  assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata};

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_push),
    .push_data (req_in),
    .pop       (issue),
    .pop_data  (req_head),
    .count     (req_cnt_unused),
    .full      (req_full),
    .empty     (req_empty)
  );

  // Credits count buffered responses plus reads already past the FIFO;
  // a same-cycle response pop is deliberately not credited.
  assign rd_inflight = INFL_W'(mem_rr_en) + INFL_W'(cap_vld);
  assign rd_credit   = (32'(rsp_count) + 32'(rd_inflight)) < RSP_DEPTH;

  // Head-of-line issue decision; a stalled read blocks everything behind it
  always_comb begin
    issue = 1'b0;
    if (!req_empty && (req_head.we || rd_credit)) issue = 1'b1;
  end

  // Issue register driving the memory pins for one cycle per command
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_rw_en <= 1'b0;
      mem_rr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en    <= issue;
      mem_rw_en <= issue && req_head.we;
      mem_rr_en <= issue && !req_head.we;
      if (issue) begin
        mem_addr  <= req_head.addr;
        mem_wdata <= req_head.wdata;
      end
    end
  end

  // Capture stage follows our own read-issued flag, not mem_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld  <= 1'b0;
      cap_addr <= '0;
    end else begin
      cap_vld  <= mem_rr_en;
      cap_addr <= mem_addr;
    end
  end

  // Sticky flag for read data captured without a valid qualifier
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err <= 1'b0;
    end else if (cap_vld && (mem_valid != 1'b1)) begin
      rd_err <= 1'b1;
    end
  end

  assign rsp_in = '{addr: cap_addr, rdata: mem_rdata};

  sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_vld),
    .push_data (rsp_in),
    .pop       (rsp_ready),
    .pop_data  (rsp_head),
    .count     (rsp_count),
    .full      (rsp_full_unused),
    .empty     (rsp_empty)
  );

  assign rsp_valid = !rsp_empty;
  assign rsp_rdata = rsp_valid ? rsp_head.rdata : '0;
  assign rsp_addr  = rsp_valid ? rsp_head.addr  : '0;

endmodule
